alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered `alu` instance between `N_REQ` requesters. Each requester submits an operand pair and opcode over a valid/ready handshake. The arbiter grants one requester at a time, drives the ALU enable for exactly one clock, and returns the result to the granted requester over a per-requester valid/ready response channel. It sits between the requesting datapath units and the single shared ALU.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 27 ++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin arbiter:
// opcode constants, arbiter state encoding and the default datapath width.
package alu_pkg;

   localparam int WIDTH_DEFAULT = 32;

   localparam logic [1:0] ALU_OP_ADD = 2'd0;
   localparam logic [1:0] ALU_OP_SUB = 2'd1;
   localparam logic [1:0] ALU_OP_AND = 2'd2;
   localparam logic [1:0] ALU_OP_OR  = 2'd3;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_EXEC = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// Registered two-operand ALU; result updates only on cycles with en high and
// otherwise holds. The result register is deliberately left without reset.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result
);

   always_ff @(posedge clk) begin
      if (en) begin
         case (op)
            ALU_OP_ADD: result <= a + b;
            ALU_OP_SUB: result <= a - b;
            ALU_OP_AND: result <= a & b;
            ALU_OP_OR:  result <= a | b;
         endcase
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered alu between N_REQ requesters,
// with one operation in flight and a per-requester valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner combinationally
// EXEC  | alu enabled for exactly one cycle with the latched operands
// RESP  | result presented to the owner until it accepts it
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*2-1:0]     req_op,
   output logic [N_REQ-1:0]       resp_valid,
   input  logic [N_REQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]       resp_data,
   output logic                   busy
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, owner_q, winner, ptr_next;
   logic [WIDTH-1:0] opnd_a_q, opnd_b_q, alu_result;
   logic [1:0]       op_q;
   logic             accept, handshake, alu_en;

   // First set bit at or above base, wrapping modulo N_REQ.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0] base);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = base;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(base) + i) % N_REQ;
         if (!found && valid[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      winner = rr_pick(req_valid, ptr_q);
   end

   always_comb begin
      ptr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      resp_valid = '0;
      alu_en     = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      handshake  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            busy = 1'b0;
            // Reset is asynchronous, so a grant must not leak out while it is held.
            if ((|req_valid) && !reset) begin
               accept            = 1'b1;
               req_ready[winner] = 1'b1;
               state_d           = ARB_EXEC;
            end
         end
         ARB_EXEC: begin
            alu_en  = 1'b1;
            state_d = ARB_RESP;
         end
         ARB_RESP: begin
            resp_valid[owner_q] = 1'b1;
            if (resp_ready[owner_q]) begin
               handshake = 1'b1;
               state_d   = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         opnd_a_q <= '0;
         opnd_b_q <= '0;
         op_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q  <= winner;
            opnd_a_q <= req_a[winner*WIDTH +: WIDTH];
            opnd_b_q <= req_b[winner*2*0 + winner*WIDTH +: WIDTH];
            op_q     <= req_op[winner*2 +: 2];
         end
         if (handshake) begin
            ptr_q <= ptr_next;
         end
      end
   end

   alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .clk   (clk),
      .en    (alu_en),
      .a     (opnd_a_q),
      .b     (opnd_b_q),
      .op    (op_q),
      .result(alu_result)
   );

   // The alu result register is not reset, so it is only visible in RESP.
   assign resp_data = (state_q == ARB_RESP) ? alu_result : '0;

endmodule
